// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared state encodings, control-bundle type and defaults for the pipeline stall controller.
package pipeline_stall_ctrl_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_LU_STALL   = 2'd2;
  localparam logic [1:0] ST_MEM_FREEZE = 2'd3;

  localparam int unsigned DEF_STALL_TIMEOUT = 256;
  localparam int unsigned DEF_CNT_W         = 32;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExBubble;
    logic pipeEn;
  } ctrl_t;

  // Bubble with the back end still running: used both in IDLE and for a load-use stall.
  localparam ctrl_t CTRL_IDLE   = 5'b00011;
  localparam ctrl_t CTRL_STALL  = 5'b00011;
  localparam ctrl_t CTRL_FREEZE = 5'b00000;
  localparam ctrl_t CTRL_BRANCH = 5'b11101;
  localparam ctrl_t CTRL_NORMAL = 5'b11001;

  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal == 0) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Load-use / branch / memory-busy stall controller with a freeze watchdog.
// Optional perf counters are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = DEF_STALL_TIMEOUT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             hazard_detected_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_en_o,
  output logic             stall_err_o,
  output logic             timeout_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_stall_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam int unsigned FRZ_W   = cntWidth(STALL_TIMEOUT);
  localparam bit          WDOG_EN = (STALL_TIMEOUT != 0);
  localparam logic [FRZ_W-1:0] FRZ_MAX  = FRZ_W'(STALL_TIMEOUT);
  localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(STALL_TIMEOUT - 1);

  logic [1:0]       stQ;
  logic [1:0]       stNext;
  ctrl_t            ctrl;
  logic             frzActive;
  logic             setStallErr;
  logic             setTimeout;
  logic             stallErrQ;
  logic             timeoutQ;
  logic [FRZ_W-1:0] frzCnt;

  // State and sticky error flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stQ       <= ST_IDLE;
      stallErrQ <= 1'b0;
      timeoutQ  <= 1'b0;
    end else begin
      stQ <= stNext;
      if (setStallErr) stallErrQ <= 1'b1;
      if (setTimeout)  timeoutQ  <= 1'b1;
    end
  end

  // Next state and Mealy controls; every non-idle state shares the RUN priority rules
  always_comb begin
    stNext      = stQ;
    ctrl        = CTRL_IDLE;
    frzActive   = 1'b0;
    setStallErr = 1'b0;
    if (stQ == ST_IDLE) begin
      if (start_i) stNext = ST_RUN;
    end else begin
      frzActive = mem_stall_i;
      if (mem_stall_i) begin
        ctrl   = CTRL_FREEZE;
        stNext = ST_MEM_FREEZE;
      end else if (hazard_detected_i) begin
        ctrl        = CTRL_STALL;
        stNext      = ST_LU_STALL;
        setStallErr = (stQ == ST_LU_STALL);
      end else if (branch_taken_i) begin
        ctrl   = CTRL_BRANCH;
        stNext = ST_RUN;
      end else begin
        ctrl   = CTRL_NORMAL;
        stNext = ST_RUN;
      end
    end
  end

  sat_counter #(.W(FRZ_W)) uFrzCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (!frzActive),
    .inc   (WDOG_EN && frzActive && (frzCnt != FRZ_MAX)),
    .cnt   (frzCnt)
  );

  // Count reaches STALL_TIMEOUT on this edge
  assign setTimeout = WDOG_EN && frzActive && (frzCnt == FRZ_LAST);

  assign pc_write_o     = ctrl.pcWrite;
  assign if_id_write_o  = ctrl.ifIdWrite;
  assign if_id_flush_o  = ctrl.ifIdFlush;
  assign id_ex_bubble_o = ctrl.idExBubble;
  assign pipe_en_o      = ctrl.pipeEn;
  assign stall_err_o    = stallErrQ;
  assign timeout_o      = timeoutQ;

`ifdef STALL_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) uLuCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (1'b0),
    .inc   (ctrl.idExBubble && (stQ != ST_IDLE)),
    .cnt   (lu_stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) uMemCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (1'b0),
    .inc   (!ctrl.pcWrite && !ctrl.ifIdWrite && !ctrl.pipeEn),
    .cnt   (mem_stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (1'b0),
    .inc   (ctrl.ifIdFlush),
    .cnt   (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: one vector table plus hand-written corner sequences.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CNT_W = 16;
  // {pc_write, if_id_write, flush, bubble, pipe_en}
  localparam logic [4:0] O_IDLE   = 5'b00011;
  localparam logic [4:0] O_NORM   = 5'b11001;
  localparam logic [4:0] O_STALL  = 5'b00011;
  localparam logic [4:0] O_BRANCH = 5'b11101;
  localparam logic [4:0] O_FREEZE = 5'b00000;

  typedef struct {
    logic       s;
    logic       h;
    logic       b;
    logic       m;
    logic [6:0] exp;
  } vec_t;

  logic clk;
  logic rst_i;
  logic start_i;
  logic hazard_detected_i;
  logic branch_taken_i;
  logic mem_stall_i;
  logic pc_write_o;
  logic if_id_write_o;
  logic if_id_flush_o;
  logic id_ex_bubble_o;
  logic pipe_en_o;
  logic stall_err_o;
  logic timeout_o;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] lu_stall_cnt_o;
  logic [CNT_W-1:0] mem_stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
`endif

  int tests;
  int failed;
  vec_t vecs[28];

  pipeline_stall_ctrl #(.STALL_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .hazard_detected_i (hazard_detected_i),
    .branch_taken_i    (branch_taken_i),
    .mem_stall_i       (mem_stall_i),
    .pc_write_o        (pc_write_o),
    .if_id_write_o     (if_id_write_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .pipe_en_o         (pipe_en_o),
    .stall_err_o       (stall_err_o),
    .timeout_o         (timeout_o)
`ifdef STALL_PERF_CNT_EN
    ,
    .lu_stall_cnt_o    (lu_stall_cnt_o),
    .mem_stall_cnt_o   (mem_stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t row(input logic s, input logic h, input logic b, input logic m,
                               input logic [4:0] o, input logic err, input logic to);
    vec_t r;
    r.s   = s;
    r.h   = h;
    r.b   = b;
    r.m   = m;
    r.exp = {o, err, to};
    return r;
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_en_o,
           stall_err_o, timeout_o};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b want %b (pc,ifw,flush,bubble,pipe_en,err,timeout)",
               name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs sampled 1 ns later
  task automatic drive(input logic s, input logic h, input logic b, input logic m);
    @(negedge clk);
    start_i           = s;
    hazard_detected_i = h;
    branch_taken_i    = b;
    mem_stall_i       = m;
    #1;
  endtask

  task automatic doReset();
    rst_i             = 1'b0;
    start_i           = 1'b0;
    hazard_detected_i = 1'b0;
    branch_taken_i    = 1'b0;
    mem_stall_i       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset", {O_IDLE, 2'b00});
    rst_i = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    vecs[0]  = row(0, 0, 0, 0, O_IDLE,   0, 0);
    vecs[1]  = row(0, 0, 0, 0, O_IDLE,   0, 0);
    vecs[2]  = row(0, 1, 0, 1, O_IDLE,   0, 0);
    vecs[3]  = row(0, 0, 1, 0, O_IDLE,   0, 0);
    vecs[4]  = row(0, 0, 0, 0, O_IDLE,   0, 0);
    vecs[5]  = row(1, 0, 0, 0, O_IDLE,   0, 0);
    vecs[6]  = row(0, 0, 0, 0, O_NORM,   0, 0);
    vecs[7]  = row(1, 0, 0, 0, O_NORM,   0, 0);
    vecs[8]  = row(0, 1, 0, 0, O_STALL,  0, 0);
    vecs[9]  = row(0, 0, 0, 0, O_NORM,   0, 0);
    vecs[10] = row(0, 1, 1, 0, O_STALL,  0, 0);
    vecs[11] = row(0, 0, 1, 0, O_BRANCH, 0, 0);
    vecs[12] = row(0, 0, 0, 0, O_NORM,   0, 0);
    vecs[13] = row(0, 0, 0, 1, O_FREEZE, 0, 0);
    vecs[14] = row(0, 0, 0, 1, O_FREEZE, 0, 0);
    vecs[15] = row(0, 1, 0, 1, O_FREEZE, 0, 0);
    vecs[16] = row(0, 0, 1, 1, O_FREEZE, 0, 0);
    vecs[17] = row(0, 0, 0, 1, O_FREEZE, 0, 0);
    vecs[18] = row(0, 0, 0, 1, O_FREEZE, 0, 0);
    vecs[19] = row(0, 0, 0, 1, O_FREEZE, 0, 0);
    vecs[20] = row(0, 0, 0, 1, O_FREEZE, 0, 0);
    vecs[21] = row(0, 0, 0, 1, O_FREEZE, 0, 1);
    vecs[22] = row(0, 0, 0, 1, O_FREEZE, 0, 1);
    vecs[23] = row(0, 1, 0, 0, O_STALL,  0, 1);
    vecs[24] = row(0, 1, 0, 0, O_STALL,  0, 1);
    vecs[25] = row(0, 0, 0, 0, O_NORM,   1, 1);
    vecs[26] = row(0, 0, 1, 0, O_BRANCH, 1, 1);
    vecs[27] = row(0, 0, 0, 0, O_NORM,   1, 1);

    doReset();
    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].h, vecs[i].b, vecs[i].m);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Two-cycle hazard from RUN, then LU_STALL straight into a memory freeze
    doReset();
    drive(1, 0, 0, 0); check("c_start",  {O_IDLE,   2'b00});
    drive(0, 0, 0, 0); check("c_run",    {O_NORM,   2'b00});
    drive(0, 1, 0, 0); check("c_haz1",   {O_STALL,  2'b00});
    drive(0, 1, 0, 0); check("c_haz2",   {O_STALL,  2'b00});
    drive(0, 0, 0, 0); check("c_errset", {O_NORM,   2'b10});
    drive(0, 0, 0, 0); check("c_errkeep",{O_NORM,   2'b10});
    drive(0, 1, 0, 0); check("c_haz3",   {O_STALL,  2'b10});
    drive(0, 0, 0, 1); check("c_lu2frz", {O_FREEZE, 2'b10});
    drive(0, 0, 0, 0); check("c_frzrel", {O_NORM,   2'b10});

    // Reset asserted mid-freeze after the watchdog has fired
    doReset();
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    repeat (8) drive(0, 0, 0, 1);
    drive(0, 0, 0, 1); check("b_timeout", {O_FREEZE, 2'b01});
    #1;
    rst_i = 1'b0;
    #1;
    check("b_async_rst", {O_IDLE, 2'b00});
`ifdef STALL_PERF_CNT_EN
    tests++;
    if ({lu_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o} !== '0) begin
      failed++;
      $display("FAIL b_perf_rst: got %0d/%0d/%0d want 0/0/0",
               lu_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o);
    end
`endif
    @(negedge clk);
    rst_i = 1'b1;
    drive(0, 1, 1, 1); check("b_idle_after", {O_IDLE, 2'b00});
    drive(1, 0, 0, 1); check("b_start_frz",  {O_IDLE, 2'b00});
    drive(0, 0, 0, 1); check("b_run_frz",    {O_FREEZE, 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
